// File: rtl/lifo_stack_param.sv
// Parametrised synchronous LIFO stack with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags, synchronous clear and
// replace-top semantics for simultaneous push+pop.
module lifo_stack_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 512,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage is deliberately not reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] data_out_reg;
    logic              data_valid_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              has_data;
    logic              is_full;
    logic [CNT_W-1:0]  top_idx;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              rd_en;
    logic              bypass;
    logic              ovf_set;
    logic              udf_set;

    assign has_data = (count_reg != '0);
    assign is_full  = (count_reg == DEPTH_C);
    assign top_idx  = count_reg - CNT_W'(1);
    // top_addr is only used while the stack holds data, so it is always in range;
    // wr_ptr is only used while not full, so it is always in range.
    assign top_addr = top_idx[ADDR_W-1:0];
    assign wr_ptr   = count_reg[ADDR_W-1:0];

    // Decode the requested operation for this cycle; clear suppresses everything.
    always_comb begin
        count_next = count_reg;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr;
        rd_en      = 1'b0;
        bypass     = 1'b0;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (!clear) begin
            if (push && !pop) begin
                if (!is_full) begin
                    wr_en      = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (pop && !push) begin
                if (has_data) begin
                    rd_en      = 1'b1;
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    udf_set = 1'b1;
                end
            end else if (push && pop) begin
                if (has_data) begin
                    // Replace-top: read the old top and overwrite it in the same cycle.
                    rd_en   = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = top_addr;
                end else begin
                    // Empty stack: hand the pushed word straight to the output.
                    bypass = 1'b1;
                end
            end
        end
    end

    // Memory write port (no reset, contents undefined after reset/clear).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Registered state: occupancy, read data, valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else if (clear) begin
            count_reg      <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            data_valid_reg <= rd_en | bypass;
            overflow_reg   <= overflow_reg | ovf_set;
            underflow_reg  <= underflow_reg | udf_set;
            // Nonblocking read returns the pre-write top on replace-top cycles.
            if (rd_en) begin
                data_out_reg <= mem[top_addr];
            end else if (bypass) begin
                data_out_reg <= data_in;
            end
        end
    end

    assign data_out     = data_out_reg;
    assign data_valid   = data_valid_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign empty        = ~has_data;
    assign full         = is_full;
    assign almost_full  = (int'(count_reg) >= AF_LEVEL);
    assign almost_empty = (int'(count_reg) <= AE_LEVEL);

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed testbench for lifo_stack_param (DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
module tb_lifo_stack_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;
    localparam int AE_LVL = 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    int checks;
    int errors;

    lifo_stack_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LVL),
        .AE_LEVEL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cycle(input logic c, input logic pu, input logic po, input logic [DATA_W-1:0] d);
        clear   = c;
        push    = pu;
        pop     = po;
        data_in = d;
        @(posedge clk);
        #1;
        $display("t=%0t clear=%0b push=%0b pop=%0b din=0x%0h -> dout=0x%0h dv=%0b count=%0d ovf=%0b udf=%0b",
                 $time, c, pu, po, d, data_out, data_valid, count, overflow, underflow);
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_count", 32'(count), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        #2 rst_n = 1'b1;

        // Basic LIFO ordering
        cycle(0, 1, 0, 8'hA1);
        cycle(0, 1, 0, 8'hA2);
        cycle(0, 1, 0, 8'hA3);
        check("t1_count3", 32'(count), 3);
        cycle(0, 0, 1, 8'h00);
        check("t1_pop1", 32'(data_out), 32'hA3);
        check("t1_dv1", 32'(data_valid), 1);
        check("t1_cnt2", 32'(count), 2);
        cycle(0, 0, 1, 8'h00);
        check("t1_pop2", 32'(data_out), 32'hA2);
        cycle(0, 0, 1, 8'h00);
        check("t1_pop3", 32'(data_out), 32'hA1);
        check("t1_dv3", 32'(data_valid), 1);
        check("t1_cnt0", 32'(count), 0);
        check("t1_empty", 32'(empty), 1);
        cycle(0, 0, 0, 8'h00);
        check("t1_dv_drop", 32'(data_valid), 0);

        // Fill to full, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, 8'(8'h10 + i));
            check("t2_cnt", 32'(count), 32'(i + 1));
            check("t2_af", 32'(almost_full), 32'((i + 1) >= AF_LVL));
            check("t2_ae", 32'(almost_empty), 32'((i + 1) <= AE_LVL));
        end
        check("t2_full", 32'(full), 1);
        check("t2_ovf_pre", 32'(overflow), 0);
        cycle(0, 1, 0, 8'hEE);
        check("t2_cnt_ovf", 32'(count), 8);
        check("t2_ovf", 32'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 1, 8'h00);
            check("t2_pop", 32'(data_out), 32'(8'h17 - i));
            check("t2_pop_dv", 32'(data_valid), 1);
        end
        check("t2_empty", 32'(empty), 1);
        check("t2_udf_pre", 32'(underflow), 0);
        cycle(0, 0, 1, 8'h00);
        check("t2_udf", 32'(underflow), 1);
        check("t2_udf_dv", 32'(data_valid), 0);
        check("t2_udf_dout", 32'(data_out), 32'h10);
        check("t2_ovf_sticky", 32'(overflow), 1);
        cycle(1, 0, 0, 8'h00);
        check("t2_clr_ovf", 32'(overflow), 0);
        check("t2_clr_udf", 32'(underflow), 0);

        // Replace-top
        cycle(0, 1, 0, 8'h11);
        cycle(0, 1, 0, 8'h22);
        cycle(0, 1, 0, 8'h33);
        cycle(0, 1, 1, 8'h55);
        check("t3_rt_dout", 32'(data_out), 32'h33);
        check("t3_rt_dv", 32'(data_valid), 1);
        check("t3_rt_cnt", 32'(count), 3);
        check("t3_rt_ovf", 32'(overflow), 0);
        cycle(0, 0, 1, 8'h00);
        check("t3_pop_new", 32'(data_out), 32'h55);
        check("t3_cnt2", 32'(count), 2);
        cycle(0, 0, 1, 8'h00);
        check("t3_pop_below", 32'(data_out), 32'h22);
        cycle(1, 0, 0, 8'h00);

        // Bypass on empty stack
        cycle(0, 1, 1, 8'h77);
        check("t4_dout", 32'(data_out), 32'h77);
        check("t4_dv", 32'(data_valid), 1);
        check("t4_cnt", 32'(count), 0);
        check("t4_ovf", 32'(overflow), 0);
        check("t4_udf", 32'(underflow), 0);

        // Clear with overflow set and a concurrent push
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(8'h20 + i));
        cycle(0, 1, 0, 8'hEE);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
        check("t5_cnt5", 32'(count), 5);
        check("t5_ovf_set", 32'(overflow), 1);
        check("t5_dout", 32'(data_out), 32'h25);
        cycle(1, 1, 0, 8'h99);
        check("t5_clr_cnt", 32'(count), 0);
        check("t5_clr_ovf", 32'(overflow), 0);
        check("t5_clr_dv", 32'(data_valid), 0);
        check("t5_clr_hold", 32'(data_out), 32'h25);
        cycle(0, 0, 1, 8'h00);
        check("t5_udf", 32'(underflow), 1);
        check("t5_udf_dv", 32'(data_valid), 0);
        check("t5_udf_cnt", 32'(count), 0);
        cycle(1, 0, 0, 8'h00);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'h40 + i));
        cycle(0, 0, 1, 8'h00);
        check("t6_pre_cnt", 32'(count), 4);
        check("t6_pre_dout", 32'(data_out), 32'h44);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cnt", 32'(count), 0);
        check("t6_rst_dout", 32'(data_out), 0);
        check("t6_rst_dv", 32'(data_valid), 0);
        check("t6_rst_empty", 32'(empty), 1);
        #1 rst_n = 1'b1;
        cycle(0, 1, 0, 8'h10);
        check("t6_cnt1", 32'(count), 1);
        cycle(0, 0, 1, 8'h00);
        check("t6_pop", 32'(data_out), 32'h10);
        check("t6_dv", 32'(data_valid), 1);
        check("t6_cnt0", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
